// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: SLICE bits per clock through one ripple stage with a
// registered carry, valid/ready on both sides, results published only when complete.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int SLICE = 2
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = (SLICE > 0) ? WIDTH / SLICE : 1;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
         $error("serial_adder: WIDTH must be >= 1 and a multiple of SLICE");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] part_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic [SLICE-1:0] a_slice;
   logic [SLICE-1:0] b_slice;
   logic [SLICE:0]   slice_res;
   logic [WIDTH-1:0] full_sum;
   logic             last_slice;
   logic             msb_carry_in;
   logic             accept;

   assign accept     = (state_q == IDLE) && in_valid;
   assign last_slice = (cnt_q == CW'(N - 1));

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = CALC;
            end
         end
         CALC: begin
            if (last_slice) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // One ripple slice; the partial result is merged into the running sum word.
   always_comb begin
      a_slice   = a_q[cnt_q*SLICE +: SLICE];
      b_slice   = b_q[cnt_q*SLICE +: SLICE];
      slice_res = {1'b0, a_slice} + {1'b0, b_slice} + {{SLICE{1'b0}}, carry_q};
      full_sum  = part_q;
      full_sum[cnt_q*SLICE +: SLICE] = slice_res[SLICE-1:0];
   end

   // Since s = a ^ b ^ c per bit, the carry into the MSB falls out of the MSB bits.
   assign msb_carry_in = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ full_sum[WIDTH-1];

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         a_q     <= '0;
         b_q     <= '0;
         part_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (accept) begin
            a_q     <= in1;
            b_q     <= sub ? ~in2 : in2;
            carry_q <= sub ? ~cin : cin;
            cnt_q   <= '0;
         end else if (state_q == CALC) begin
            part_q  <= full_sum;
            carry_q <= slice_res[SLICE];
            cnt_q   <= cnt_q + 1'b1;
            if (last_slice) begin
               sum_q  <= full_sum;
               cout_q <= slice_res[SLICE];
               ovf_q  <= msb_carry_in ^ slice_res[SLICE];
            end
         end
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
